alu_req_arbiter: RTL

//  Shares one alu_design instance between two requesters using round-robin arbitration.

---
 rtl/alu_req_arbiter.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter
// Round-robin front end that shares a single ALU between two requesters.
// One request is accepted at a time over a valid/ready handshake. The
// latched packet is driven onto the ALU, and the FSM waits out the
// command-dependent latency. The ALU result is then captured and returned
// as a one-cycle response tagged with the owning requester.

module alu_req_arbiter #(
    parameter int OPERAND_WIDTH = 8,
    parameter int CMD_WIDTH     = 4,
    parameter int LAT_STD       = 1,
    parameter int LAT_MUL       = 2,
    parameter int MUL_CMD_A     = 9,
    parameter int MUL_CMD_B     = 10,
    // MODE + INP_VALID[1:0] + CMD + OPA + OPB + CIN
    localparam int PKT_W        = 4 + CMD_WIDTH + 2 * OPERAND_WIDTH,
    localparam int RES_W        = 2 * OPERAND_WIDTH
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [1:0]               REQ_VALID,
    output logic [1:0]               REQ_READY,
    input  logic [PKT_W-1:0]         REQ0_DATA,
    input  logic [PKT_W-1:0]         REQ1_DATA,
    output logic                     ALU_CE,
    output logic                     ALU_MODE,
    output logic [1:0]               ALU_INP_VALID,
    output logic [CMD_WIDTH-1:0]     ALU_CMD,
    output logic [OPERAND_WIDTH-1:0] ALU_OPA,
    output logic [OPERAND_WIDTH-1:0] ALU_OPB,
    output logic                     ALU_CIN,
    input  logic [RES_W-1:0]         ALU_RES,
    input  logic [5:0]               ALU_FLAGS,
    output logic                     RSP_VALID,
    output logic                     RSP_ID,
    output logic [RES_W-1:0]         RSP_RES,
    output logic [5:0]               RSP_FLAGS,
    output logic                     BUSY
);

    localparam int LAT_MAX = (LAT_MUL > LAT_STD) ? LAT_MUL : LAT_STD;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);
    localparam int CMD_LSB = 2 * OPERAND_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_s;
    logic [CNT_W-1:0]     lat_r;
    logic [PKT_W-1:0]     pkt_r;
    logic                 id_r;
    logic                 last_grant_r;
    logic                 active_r;
    logic                 rsp_valid_r;
    logic                 rsp_id_r;
    logic [RES_W-1:0]     rsp_res_r;
    logic [5:0]           rsp_flags_r;

    logic [1:0]           grant_s;
    logic                 win_id_s;
    logic [PKT_W-1:0]     win_pkt_s;
    logic                 win_mode_s;
    logic [CMD_WIDTH-1:0] win_cmd_s;
    logic [CNT_W-1:0]     win_lat_s;
    logic                 accept_s;

    // Round-robin winner selection; ready is only offered in IDLE and never during reset
    always_comb begin
        grant_s  = 2'b00;
        win_id_s = 1'b0;
        if ((state_r == ST_IDLE) && !RST) begin
            case (REQ_VALID)
                2'b01: begin
                    grant_s  = 2'b01;
                    win_id_s = 1'b0;
                end
                2'b10: begin
                    grant_s  = 2'b10;
                    win_id_s = 1'b1;
                end
                2'b11: begin
                    win_id_s = ~last_grant_r;
                    grant_s  = last_grant_r ? 2'b01 : 2'b10;
                end
                default: begin
                    grant_s  = 2'b00;
                    win_id_s = 1'b0;
                end
            endcase
        end else begin
            grant_s  = 2'b00;
            win_id_s = 1'b0;
        end
    end

    assign accept_s   = |grant_s;
    assign win_pkt_s  = win_id_s ? REQ1_DATA : REQ0_DATA;
    assign win_mode_s = win_pkt_s[PKT_W-1];
    assign win_cmd_s  = win_pkt_s[CMD_LSB +: CMD_WIDTH];

    // Latency of the winning packet: multiplies in arithmetic mode take the long path
    always_comb begin
        win_lat_s = CNT_W'(LAT_STD);
        if (win_mode_s && ((win_cmd_s == CMD_WIDTH'(MUL_CMD_A)) ||
                           (win_cmd_s == CMD_WIDTH'(MUL_CMD_B)))) begin
            win_lat_s = CNT_W'(LAT_MUL);
        end else begin
            win_lat_s = CNT_W'(LAT_STD);
        end
    end

    // Next-state and latency counter logic
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (lat_r <= CNT_W'(1)) begin
                    state_s = ST_CAPTURE;
                end else begin
                    state_s = ST_WAIT;
                    cnt_s   = lat_r - CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (cnt_r <= CNT_W'(1)) begin
                    state_s = ST_CAPTURE;
                end else begin
                    state_s = ST_WAIT;
                    cnt_s   = cnt_r - CNT_W'(1);
                end
            end
            ST_CAPTURE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // FSM state, latency counter and the ALU-enable/busy flag
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            active_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            active_r <= (state_s != ST_IDLE);
        end
    end

    // Latch the accepted packet, its owner and latency; the packet doubles as the ALU drive
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pkt_r        <= {PKT_W{1'b0}};
            id_r         <= 1'b0;
            lat_r        <= {CNT_W{1'b0}};
            last_grant_r <= 1'b1;
        end else if (accept_s) begin
            pkt_r        <= win_pkt_s;
            id_r         <= win_id_s;
            lat_r        <= win_lat_s;
            last_grant_r <= win_id_s;
        end else begin
            pkt_r        <= pkt_r;
            id_r         <= id_r;
            lat_r        <= lat_r;
            last_grant_r <= last_grant_r;
        end
    end

    // Capture the ALU result at the end of CAPTURE and pulse the response valid once
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_res_r   <= {RES_W{1'b0}};
            rsp_flags_r <= 6'b000000;
        end else if (state_r == ST_CAPTURE) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= id_r;
            rsp_res_r   <= ALU_RES;
            rsp_flags_r <= ALU_FLAGS;
        end else begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= rsp_id_r;
            rsp_res_r   <= rsp_res_r;
            rsp_flags_r <= rsp_flags_r;
        end
    end

    assign REQ_READY     = grant_s;
    assign ALU_CE        = active_r;
    assign BUSY          = active_r;
    assign ALU_MODE      = pkt_r[PKT_W-1];
    assign ALU_INP_VALID = pkt_r[PKT_W-2 -: 2];
    assign ALU_CMD       = pkt_r[CMD_LSB +: CMD_WIDTH];
    assign ALU_OPA       = pkt_r[OPERAND_WIDTH+1 +: OPERAND_WIDTH];
    assign ALU_OPB       = pkt_r[1 +: OPERAND_WIDTH];
    assign ALU_CIN       = pkt_r[0];
    assign RSP_VALID     = rsp_valid_r;
    assign RSP_ID        = rsp_id_r;
    assign RSP_RES       = rsp_res_r;
    assign RSP_FLAGS     = rsp_flags_r;

endmodule
